// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and defaults for the GCD datapath modulo unit.
//   state_t   : modulo sequencer states (IDLE, CALC, DONE)
//   WIDTH_DEF : default operand width
//   CNT_W_DEF : step counter width for the default operand width
package gcd_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/modulo_step.sv
// modulo_step: one combinational restoring-division step.
//   rem      in  WIDTH  partial remainder (always < b between steps)
//   dvd      in  WIDTH  dividend shift register, quotient bits enter at the LSB
//   b        in  WIDTH  divisor
//   rem_next out WIDTH  partial remainder after this step
//   dvd_next out WIDTH  dvd shifted left with the new quotient bit appended
module modulo_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next
);

  logic [WIDTH:0] t;
  logic           q_bit;

  always_comb begin
    t     = {rem, dvd[WIDTH-1]};
    q_bit = (t >= {1'b0, b});
    // When subtracting, the result is < b, so the low WIDTH bits are exact.
    rem_next = q_bit ? (t[WIDTH-1:0] - b) : t[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/modulo_seq_unit.sv
// modulo_seq_unit: iterative unsigned modulo/divide responder for the GCD datapath.
//   clk             in   single clock
//   rst             in   asynchronous active-low reset
//   modulo_start_i  in   request strobe, accepted in IDLE or DONE
//   op_a_i, op_b_i  in   dividend / divisor, captured on the accepting edge
//   res_o, quot_o   out  remainder / quotient, held until the next result
//   modulo_ready_o  out  one-cycle completion pulse
//   busy_o          out  high while calculating
//   div_zero_o      out  last completed request had b == 0
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | one restoring step per cycle, WIDTH steps total
// DONE  | result registered; ready pulses on the following cycle
module modulo_seq_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             modulo_start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [WIDTH-1:0] res_o,
  output logic [WIDTH-1:0] quot_o,
  output logic             modulo_ready_o,
  output logic             busy_o,
  output logic             div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   dvd_next;
  logic               accept;

  assign accept = modulo_start_i && (state != CALC);

  modulo_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .b        (b_reg),
    .rem_next (rem_next),
    .dvd_next (dvd_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      b_reg          <= '0;
      rem            <= '0;
      dvd            <= '0;
      res_o          <= '0;
      quot_o         <= '0;
      modulo_ready_o <= 1'b0;
      busy_o         <= 1'b0;
      div_zero_o     <= 1'b0;
    end else begin
      // The pulse is issued on the edge that leaves DONE, so it lasts one cycle
      // even when a back-to-back request is accepted in DONE.
      modulo_ready_o <= (state == DONE);
      if (accept) begin
        b_reg      <= op_b_i;
        dvd        <= op_a_i;
        rem        <= '0;
        div_zero_o <= 1'b0;
        if (op_b_i == '0) begin
          state      <= DONE;
          res_o      <= op_a_i;
          quot_o     <= '1;
          div_zero_o <= 1'b1;
        end else begin
          state  <= CALC;
          cnt    <= CNT_W'(WIDTH - 1);
          busy_o <= 1'b1;
        end
      end else if (state == CALC) begin
        rem <= rem_next;
        dvd <= dvd_next;
        if (cnt == '0) begin
          state  <= DONE;
          busy_o <= 1'b0;
          res_o  <= rem_next;
          quot_o <= dvd_next;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_modulo_seq_unit.sv
// tb_modulo_seq_unit: directed bench for modulo_seq_unit with hand-computed results.
module tb_modulo_seq_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] res;
  logic [W-1:0] quot;
  logic         ready;
  logic         busy;
  logic         dz;

  int vectors = 0;
  int miscompares = 0;

  modulo_seq_unit #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .modulo_start_i (start),
    .op_a_i         (op_a),
    .op_b_i         (op_b),
    .res_o          (res),
    .quot_o         (quot),
    .modulo_ready_o (ready),
    .busy_o         (busy),
    .div_zero_o     (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready is seen; -1 on timeout.
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  // Present a request so that the next edge (edge 0) accepts it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
    op_a  = 16'hDEAD;
    op_b  = 16'h0003;
  endtask

  initial begin
    int n;
    int pulses;

    // Reset state
    #12;
    chk("rst_res", 32'(res), 32'h0);
    chk("rst_quot", 32'(quot), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dz", 32'(dz), 32'h0);
    rst = 1'b1;
    tick();
    tick();

    // Divide by zero: ready after edge 1
    issue(16'd123, 16'd0);
    chk("dz_busy", 32'(busy), 32'h0);
    wait_ready(n);
    chk("dz_latency", 32'(n), 32'd1);
    chk("dz_res", 32'(res), 32'd123);
    chk("dz_quot", 32'(quot), 32'hFFFF);
    chk("dz_flag", 32'(dz), 32'h1);

    // 48 mod 18; div_zero cleared on accept, old outputs held during CALC
    tick();
    issue(16'd48, 16'd18);
    chk("a48_busy", 32'(busy), 32'h1);
    chk("a48_dz_clr", 32'(dz), 32'h0);
    chk("a48_hold_res", 32'(res), 32'd123);
    wait_ready(n);
    chk("a48_latency", 32'(n), 32'd17);
    chk("a48_res", 32'(res), 32'd12);
    chk("a48_quot", 32'(quot), 32'd2);
    chk("a48_dz", 32'(dz), 32'h0);
    chk("a48_busy_done", 32'(busy), 32'h0);
    tick();
    chk("a48_pulse_1cyc", 32'(ready), 32'h0);

    // a < b: no early exit
    issue(16'd7, 16'd20);
    wait_ready(n);
    chk("a7_latency", 32'(n), 32'd17);
    chk("a7_res", 32'(res), 32'd7);
    chk("a7_quot", 32'(quot), 32'd0);

    // Max dividend, b = 1
    tick();
    issue(16'hFFFF, 16'd1);
    wait_ready(n);
    chk("ffff_latency", 32'(n), 32'd17);
    chk("ffff_res", 32'(res), 32'd0);
    chk("ffff_quot", 32'(quot), 32'hFFFF);

    // Start during CALC is ignored: 100/7 = 14 r 2
    tick();
    issue(16'd100, 16'd7);
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1;
    op_a  = 16'd5;
    op_b  = 16'd3;
    tick();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'h1);
    wait_ready(n);
    chk("ign_latency", 32'(n), 32'd12);
    chk("ign_res", 32'(res), 32'd2);
    chk("ign_quot", 32'(quot), 32'd14);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ready) pulses++;
    end
    chk("ign_extra_pulses", 32'(pulses), 32'd0);

    // Back-to-back: start held through DONE, 30 mod 12 = 6 twice
    start = 1'b1;
    op_a  = 16'd30;
    op_b  = 16'd12;
    tick();
    wait_ready(n);
    chk("b2b_lat1", 32'(n), 32'd17);
    chk("b2b_res1", 32'(res), 32'd6);
    chk("b2b_busy", 32'(busy), 32'h1);
    start = 1'b0;
    wait_ready(n);
    chk("b2b_lat2", 32'(n), 32'd17);
    chk("b2b_res2", 32'(res), 32'd6);
    chk("b2b_quot2", 32'(quot), 32'd2);

    // Reset mid-CALC
    tick();
    issue(16'd48, 16'd18);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_res", 32'(res), 32'h0);
    chk("mid_rst_quot", 32'(quot), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (ready) pulses++;
    end
    chk("mid_rst_no_pulse", 32'(pulses), 32'd0);

    // Recovery after reset
    issue(16'd7, 16'd20);
    wait_ready(n);
    chk("rec_latency", 32'(n), 32'd17);
    chk("rec_res", 32'(res), 32'd7);
    chk("rec_quot", 32'(quot), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
